// File: rtl/sar_sample_averager.sv
// SAR ADC conversion sequencer and result averager.
// Requests conversions through adc_hold and captures adc_result on each rising
// edge of adc_eoc. After 2^LOG2_AVG samples it presents the truncated mean on a
// valid/ready output. A watchdog abandons the run if end-of-conversion never
// arrives while holding.
module sar_sample_averager #(
    parameter int N_BITS         = 10,
    parameter int LOG2_AVG       = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              adc_eoc,
    input  logic [N_BITS-1:0] adc_result,
    output logic              adc_hold,
    output logic [N_BITS-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              busy,
    output logic              timeout
);

    localparam int ACC_W = N_BITS + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** LOG2_AVG);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP,
        S_OUT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [WD_W-1:0]   wd;
    logic              eoc_q;
    logic              eoc_rise;

    // Control strobes decoded from the current state and inputs.
    logic              clr_run;
    logic              acc_en;
    logic              latch_en;
    logic              wd_inc;
    logic              set_timeout;
    logic              clr_timeout;

    assign eoc_rise = adc_eoc & ~eoc_q;

    // Outputs are pure decodes of the registered state, so they never glitch
    // on input changes.
    assign adc_hold  = (state == S_HOLD);
    assign busy      = (state != S_IDLE);
    assign avg_valid = (state == S_OUT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and control strobe decode.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        next_state  = state;
        clr_run     = 1'b0;
        acc_en      = 1'b0;
        latch_en    = 1'b0;
        wd_inc      = 1'b0;
        set_timeout = 1'b0;
        clr_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr_run     = 1'b1;
                    clr_timeout = 1'b1;
                    next_state  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (eoc_rise) begin
                    acc_en     = 1'b1;
                    next_state = S_GAP;
                end else if (wd == WD_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_GAP: begin
                // Waiting for eoc to fall keeps a stale-high eoc from being
                // seen as a second rising edge in the next HOLD.
                if (!adc_eoc) begin
                    if (count == CNT_FULL) begin
                        latch_en   = 1'b1;
                        next_state = S_OUT;
                    end else begin
                        next_state = S_HOLD;
                    end
                end
            end
            S_OUT: begin
                if (avg_ready) begin
                    if (start) begin
                        clr_run    = 1'b1;
                        next_state = S_HOLD;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: edge detector, accumulator, sample counter, watchdog, flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            eoc_q    <= 1'b0;
            acc      <= '0;
            count    <= '0;
            wd       <= '0;
            timeout  <= 1'b0;
            avg_data <= '0;
        end else begin
            eoc_q <= adc_eoc;

            // A watchdog expiry discards the partial sum along with the run.
            if (clr_run || set_timeout) begin
                acc   <= '0;
                count <= '0;
                wd    <= '0;
            end else if (acc_en) begin
                acc   <= acc + ACC_W'(adc_result);
                count <= count + CNT_W'(1);
                wd    <= '0;
            end else if (wd_inc) begin
                wd <= wd + WD_W'(1);
            end

            if (set_timeout)      timeout <= 1'b1;
            else if (clr_timeout) timeout <= 1'b0;

            // Mean by truncating shift; acc is wide enough that it never wraps.
            if (latch_en) avg_data <= N_BITS'(acc >> LOG2_AVG);
        end
    end

endmodule

// File: tb/tb_sar_sample_averager.sv
// Self-checking bench for sar_sample_averager (N_BITS=10, LOG2_AVG=2,
// TIMEOUT_CYCLES=64). A small ADC model answers hold requests; expected means
// come from a table of hand-computed constants or from plain integer averaging.
module tb_sar_sample_averager;

    localparam int N_BITS  = 10;
    localparam int NSAMP   = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              adc_eoc;
    logic [N_BITS-1:0] adc_result;
    logic              adc_hold;
    logic [N_BITS-1:0] avg_data;
    logic              avg_valid;
    logic              avg_ready;
    logic              busy;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    // Observed event counters, sampled on the falling edge.
    int hold_rises = 0;
    int xfers      = 0;
    logic hold_d   = 1'b0;

    sar_sample_averager #(
        .N_BITS        (N_BITS),
        .LOG2_AVG      (2),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .adc_eoc   (adc_eoc),
        .adc_result(adc_result),
        .adc_hold  (adc_hold),
        .avg_data  (avg_data),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Count hold pulses and valid/ready transfers away from the active edge.
    always @(negedge clk) begin
        if (adc_hold && !hold_d) hold_rises++;
        hold_d = adc_hold;
        if (avg_valid && avg_ready) xfers++;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [N_BITS-1:0] s [NSAMP];
        int                stale_idx;
        int                ready_delay;
        logic [N_BITS-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC model: wait for a hold request, then raise eoc with the result for
    // eoc_len cycles and drop it again.
    task automatic convert(input logic [N_BITS-1:0] v, input int eoc_len);
        int n = 0;
        while (!adc_hold && n < 200) begin
            tick();
            n++;
        end
        check("hold_request", {31'b0, adc_hold}, 1);
        adc_eoc    = 1'b1;
        adc_result = v;
        tick();
        check("hold_drop", {31'b0, adc_hold}, 0);
        for (int i = 1; i < eoc_len; i++) begin
            adc_result = ~v;
            tick();
            check("stale_gap_hold", {31'b0, adc_hold}, 0);
            check("stale_gap_busy", {31'b0, busy}, 1);
        end
        adc_eoc    = 1'b0;
        adc_result = '0;
        tick();
    endtask

    // One single-shot average: start, four conversions, optional backpressure
    // with spurious eoc pulses, then transfer and return to idle.
    task automatic run_avg(input string name, input logic [N_BITS-1:0] s [NSAMP],
                           input int stale_idx, input int ready_delay,
                           input logic [N_BITS-1:0] exp);
        int hr0;
        int xf0;
        hr0       = hold_rises;
        xf0       = xfers;
        avg_ready = (ready_delay == 0);
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_hold_after_start"}, {31'b0, adc_hold}, 1);
        for (int i = 0; i < NSAMP; i++) convert(s[i], (i == stale_idx) ? 5 : 1);
        check({name, "_valid"}, {31'b0, avg_valid}, 1);
        check({name, "_data"}, {22'b0, avg_data}, {22'b0, exp});
        for (int d = 0; d < ready_delay; d++) begin
            adc_eoc    = d[0] ? 1'b0 : 1'b1;
            adc_result = 10'h3ff;
            tick();
            check({name, "_bp_valid"}, {31'b0, avg_valid}, 1);
            check({name, "_bp_data"}, {22'b0, avg_data}, {22'b0, exp});
            check({name, "_bp_hold"}, {31'b0, adc_hold}, 0);
        end
        adc_eoc   = 1'b0;
        avg_ready = 1'b1;
        tick();
        check({name, "_valid_after_xfer"}, {31'b0, avg_valid}, 0);
        check({name, "_busy_after_xfer"}, {31'b0, busy}, 0);
        check({name, "_data_held"}, {22'b0, avg_data}, {22'b0, exp});
        check({name, "_hold_pulses"}, hold_rises - hr0, NSAMP);
        check({name, "_xfers"}, xfers - xf0, 1);
    endtask

    initial begin
        logic [N_BITS-1:0] smp [NSAMP];
        int sum;
        int n;
        int xf0;

        tbl[0].s = '{10'd100, 10'd101, 10'd102, 10'd103}; tbl[0].stale_idx = -1; tbl[0].ready_delay = 0;  tbl[0].exp = 10'd101;
        tbl[1].s = '{10'd1023, 10'd1023, 10'd1023, 10'd1023}; tbl[1].stale_idx = -1; tbl[1].ready_delay = 0; tbl[1].exp = 10'd1023;
        tbl[2].s = '{10'd0, 10'd0, 10'd0, 10'd3};         tbl[2].stale_idx = -1; tbl[2].ready_delay = 0;  tbl[2].exp = 10'd0;
        tbl[3].s = '{10'd500, 10'd510, 10'd520, 10'd531}; tbl[3].stale_idx = -1; tbl[3].ready_delay = 10; tbl[3].exp = 10'd515;
        tbl[4].s = '{10'd7, 10'd9, 10'd11, 10'd13};       tbl[4].stale_idx = 1;  tbl[4].ready_delay = 0;  tbl[4].exp = 10'd10;
        tbl[5].s = '{10'd1, 10'd2, 10'd3, 10'd5};         tbl[5].stale_idx = -1; tbl[5].ready_delay = 2;  tbl[5].exp = 10'd2;

        reset      = 1'b1;
        start      = 1'b0;
        adc_eoc    = 1'b0;
        adc_result = '0;
        avg_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_hold", {31'b0, adc_hold}, 0);
        check("rst_valid", {31'b0, avg_valid}, 0);
        check("rst_data", {22'b0, avg_data}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_timeout", {31'b0, timeout}, 0);

        // Table-driven averages.
        for (int i = 0; i < 6; i++) run_avg($sformatf("vec%0d", i), tbl[i].s,
                                            tbl[i].stale_idx, tbl[i].ready_delay, tbl[i].exp);

        // Watchdog: eoc never arrives.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (adc_hold && n < 200) begin
            n++;
            tick();
        end
        check("wd_hold_cycles", n, TIMEOUT);
        check("wd_timeout", {31'b0, timeout}, 1);
        check("wd_busy", {31'b0, busy}, 0);
        check("wd_valid", {31'b0, avg_valid}, 0);
        tick();
        check("wd_timeout_sticky", {31'b0, timeout}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_cleared_by_start", {31'b0, timeout}, 0);
        check("wd_restart_hold", {31'b0, adc_hold}, 1);

        // Reset mid-sequence after two of four samples.
        convert(10'd300, 1);
        convert(10'd301, 1);
        reset = 1'b1;
        tick();
        check("midrst_hold", {31'b0, adc_hold}, 0);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_valid", {31'b0, avg_valid}, 0);
        check("midrst_data", {22'b0, avg_data}, 0);
        check("midrst_timeout", {31'b0, timeout}, 0);
        reset = 1'b0;
        tick();
        smp = '{10'd200, 10'd200, 10'd200, 10'd200};
        run_avg("post_reset", smp, -1, 0, 10'd200);

        // Continuous mode: start held for three averages.
        xf0       = xfers;
        avg_ready = 1'b1;
        start     = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            sum = 0;
            for (int i = 0; i < NSAMP; i++) begin
                smp[i] = N_BITS'($urandom_range(0, 1023));
                sum += int'(smp[i]);
            end
            for (int i = 0; i < NSAMP; i++) convert(smp[i], 1);
            check("cont_valid", {31'b0, avg_valid}, 1);
            check("cont_data", {22'b0, avg_data}, sum / NSAMP);
            if (r == 2) start = 1'b0;
            tick();
            check("cont_hold_rerise", {31'b0, adc_hold}, (r < 2) ? 1 : 0);
            check("cont_busy", {31'b0, busy}, (r < 2) ? 1 : 0);
        end
        check("cont_xfers", xfers - xf0, 3);

        // Randomized runs against the integer-average model.
        for (int k = 0; k < 10; k++) begin
            sum = 0;
            for (int i = 0; i < NSAMP; i++) begin
                smp[i] = N_BITS'($urandom_range(0, 1023));
                sum += int'(smp[i]);
            end
            run_avg($sformatf("rand%0d", k), smp,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                    int'($urandom_range(0, 4)), N_BITS'(sum / NSAMP));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
